// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks the data memory read port from word 0 upward and streams each word MSB byte first
// over a valid/ready byte interface.
module mem_dump_reader #(
    parameter int NB_BITS = 32,
    parameter int NB_ADDR = 8,
    parameter int N_WORDS = 256
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_tx_ready,
    input  logic [NB_BITS-1:0] i_mem_data,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic               o_mem_re,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    output logic               o_busy,
    output logic               o_done
);
    localparam int N_BYTES = NB_BITS / 8;
    localparam int NB_BCNT = N_BYTES > 1 ? $clog2(N_BYTES) : 1;
    localparam logic [NB_ADDR-1:0] LAST_WORD = NB_ADDR'(N_WORDS - 1);
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(N_BYTES - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

    state_t             state, state_next;
    logic [NB_ADDR-1:0] word_cnt;
    logic [NB_BCNT-1:0] byte_cnt;
    logic [NB_BITS-1:0] shreg;
    logic               hs, last_byte;

    assign hs        = (state == SEND) && i_tx_ready;
    assign last_byte = hs && (byte_cnt == LAST_BYTE);

    always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_next;

    always_comb begin
        state_next = state;
        o_mem_addr = word_cnt;
        o_mem_re   = (state == READ);
        o_tx_valid = (state == SEND);
        o_tx_data  = shreg[NB_BITS-1 -: 8];
        o_busy     = (state != IDLE);
        o_done     = (state == DONE);
        case (state)
            IDLE:    state_next = i_start ? READ : IDLE;
            READ:    state_next = WAIT;
            WAIT:    state_next = SEND;
            SEND:    state_next = !last_byte ? SEND : (word_cnt == LAST_WORD) ? DONE : READ;
            default: state_next = IDLE;
        endcase
    end

    // The word counter stops at the terminal address, so it never wraps back to 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_cnt <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
        end else begin
            if (state == IDLE && i_start)
                word_cnt <= '0;
            else if (last_byte && word_cnt != LAST_WORD)
                word_cnt <= word_cnt + 1'b1;
            if (state == WAIT) begin
                shreg    <= i_mem_data;
                byte_cnt <= '0;
            end else if (hs) begin
                shreg    <= shreg << 8;
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Debug-side reader for the pipeline data memory: on command, walks the data memory's second (read-only) port word by word, from word 0 to N_WORDS-1.
- Serializes each 32-bit word MSB byte first onto a byte stream with a valid/ready handshake, normally feeding the debug UART transmitter.
- Sits between the data memory read port and the debug unit. It lets the host dump memory contents after a program run without touching the MEM stage write path.

Parameters:
- NB_BITS, 32: memory word width; must be a multiple of 8.
- NB_ADDR, 8: width of the word address to the memory read port.
- N_WORDS, 256: number of words dumped. Range 1..2^NB_ADDR.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  dump request, sampled only in IDLE.
- i_tx_ready  input  1  downstream byte accept.
- i_mem_data  input  NB_BITS  memory read data, valid the cycle after o_mem_re.
- o_mem_addr  output  NB_ADDR  word address to the memory read port.
- o_mem_re  output  1  memory read enable.
- o_tx_data  output  8  byte to transmitter.
- o_tx_valid  output  1  o_tx_data valid.
- o_busy  output  1  high in any state other than IDLE.
- o_done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (i_rst=1 at posedge):
  - State goes to IDLE.
  - Word counter, byte counter and shift register go to 0.
  - All outputs go to 0.
  - A reset mid-dump aborts immediately. There is no done pulse and no further bytes.
- All outputs are registered or decoded from registered state. There are no combinational paths from i_tx_ready to o_tx_valid.
- IDLE:
  - If i_start=1, go to READ, with word counter = 0.
  - Otherwise stay in IDLE.
- READ (1 cycle):
  - o_mem_re=1, o_mem_addr = word counter.
  - Always go to WAIT.
- WAIT (1 cycle):
  - i_mem_data is valid (synchronous RAM, 1-cycle latency).
  - Latch i_mem_data into the shift register and clear the byte counter.
  - Go to SEND.
- SEND:
  - o_tx_valid=1, o_tx_data = shift register [NB_BITS-1 -: 8].
  - Handshake occurs when o_tx_valid & i_tx_ready at a posedge.
    - On handshake: shift left by 8, zero-fill, and increment the byte counter.
  - While i_tx_ready=0, o_tx_data and o_tx_valid hold stable. Stalling can last indefinitely.
  - On the handshake of byte NB_BITS/8-1:
    - If word counter == N_WORDS-1, go to DONE.
    - Otherwise increment the word counter and go to READ.
- DONE (1 cycle):
  - o_done=1, o_busy=1, o_tx_valid=0.
  - Go to IDLE.
- o_mem_addr holds the word counter value in every state. o_mem_re is high only in READ.
- i_start outside IDLE is ignored; there is no queuing. i_start in the same cycle as DONE is also ignored. A new dump needs i_start in IDLE.
- Timing with i_tx_ready held at 1:
  - Each word takes 2 + NB_BITS/8 cycles (6 for 32 bits).
  - First byte valid 2 cycles after entering READ.
  - o_done asserted 1 + 6*N_WORDS cycles after the i_start sample cycle.
- Word counter wrap: unreachable by construction, because the terminal count is N_WORDS-1. With N_WORDS = 2^NB_ADDR, the last address is all ones, and the counter is not incremented past it.
- N_WORDS=1: a single READ/WAIT/SEND pass, then DONE.

Test Plan:
- Reset mid-dump: reset asserted in SEND of word 1 -> next cycle state IDLE, o_tx_valid=0, o_busy=0, o_mem_addr=0, no o_done pulse; a subsequent i_start restarts from word 0.
- Basic dump: N_WORDS=4, memory = {0x11223344, 0xAABBCCDD, 0x00000000, 0xDEADBEEF}, i_tx_ready=1, i_start pulsed at cycle 0:
  - bytes 11 22 33 44 AA BB CC DD 00 00 00 00 DE AD BE EF on consecutive handshakes;
  - o_mem_re high at cycles 1, 7, 13, 19 with addr 0..3;
  - o_done at cycle 25.
- Backpressure: i_tx_ready=0 for 5 cycles while byte 0x22 is presented -> o_tx_data=0x22 and o_tx_valid=1 for all 5 cycles; no byte lost or duplicated; total stream unchanged.
- Start while busy: i_start pulsed during WAIT and during SEND -> no restart, word sequence unaffected, exactly one o_done.
- Full range: N_WORDS=256, NB_ADDR=8, mem[i]=i -> last word read at o_mem_addr=0xFF, final 4 bytes 00 00 00 FF, then o_done; no read of address 0 after 0xFF.
- Random ready: i_tx_ready random at 50% over a full dump -> the byte stream matches the memory image MSB-first, and o_busy stays high from the cycle after i_start until the cycle after o_done.
